// File: rtl/dsc_mul4_if.sv
// Operand/result bundle for the four-input DSC multiplier.
interface dsc_mul4_if #(
  parameter int WIDTH = 6
);
  logic               en;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic [WIDTH-1:0]   d;
  logic [4*WIDTH-1:0] z;
  logic               ov;

  modport master (output en, a, b, c, d, input z, ov);
  modport slave  (input en, a, b, c, d, output z, ov);
endinterface

// File: rtl/dsc_mul4.sv
// Four-input deterministic stochastic-computing multiplier.
// Nested digit counters sweep every (cD,cC,cB,cA) tuple once; each operand is
// turned into a unary stream by a strict compare against its digit, the four
// streams are ANDed and the ones counted, giving a*b*c*d after 2^(4*WIDTH)
// enabled cycles.

// Generic wrapping up-counter; overflow is the carry into the next digit.
module counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // count up on enable, wrap naturally from all-ones to zero
  always_ff @(posedge clk) begin
    if (!rst)    out <= '0;
    else if (en) out <= out + ONE;
  end

  assign overflow = en & (&out);
endmodule

module dsc_mul4 #(
  parameter int WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  dsc_mul4_if.slave  bus
);
  localparam int ZW = 4 * WIDTH;
  localparam logic [ZW-1:0] ZONE = ZW'(1);

  logic [3:0][WIDTH-1:0] dig;
  logic [3:0][WIDTH-1:0] opnd;
  logic [4:0]            carry;
  logic [3:0]            gt;
  logic                  run;
  logic                  s;
  logic [ZW-1:0]         z_q;
  logic                  ov_q;

  // digit 0 (cA) is least significant; operands line up with their digit
  assign opnd  = {bus.d, bus.c, bus.b, bus.a};
  assign run   = bus.en & ~ov_q;
  assign carry[0] = run;

  // carry chain of digit counters; stream bit per digit is a strict compare
  for (genvar i = 0; i < 4; i++) begin : g_dig
    counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .en       (carry[i]),
      .out      (dig[i]),
      .overflow (carry[i+1])
    );
    assign gt[i] = opnd[i] > dig[i];
  end

  assign s = &gt;

  // accumulate ones of the product stream; done flag set by the last carry
  // and kept sticky so the whole datapath freezes until the next reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      z_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      if (run & s) z_q  <= z_q + ZONE;
      if (carry[4]) ov_q <= 1'b1;
    end
  end

  assign bus.z  = z_q;
  assign bus.ov = ov_q;
endmodule

// File: tb/tb_dsc_mul4.sv
// Directed bench for dsc_mul4 at WIDTH=2 (256-cycle sweep).
module tb_dsc_mul4;
  localparam int W = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dsc_mul4_if #(.WIDTH(W)) bus ();

  dsc_mul4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: ones produced in the first n sweep positions
  function automatic int model_z(int a, int b, int c, int d, int n);
    int acc;
    acc = 0;
    for (int k = 0; k < n; k++)
      if (a > (k & 3) && b > ((k >> 2) & 3) && c > ((k >> 4) & 3) && d > ((k >> 6) & 3))
        acc++;
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(int a, int b, int c, int d);
    bus.a = W'(a);
    bus.b = W'(b);
    bus.c = W'(c);
    bus.d = W'(d);
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    bus.en = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // run with en high until ov or the cycle bound; returns edges taken
  task automatic run_to_ov(output int cyc);
    bus.en = 1'b1;
    cyc = 0;
    while (bus.ov !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    int cyc;
    set_ops(3, 3, 3, 3);
    rst = 1'b0;
    bus.en = 1'b1;
    tick();
    tick();
    total++;
    if (bus.z !== 8'd0 || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: z=%0d ov=%0b required z=0 ov=0", bus.z, bus.ov);
    end
    rst = 1'b1;
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (bus.z !== 8'd0 || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL hold_en_low: z=%0d ov=%0b required z=0 ov=0", bus.z, bus.ov);
    end
    run_to_ov(cyc);
    total++;
    if (cyc != 256) begin
      bad++;
      $display("FAIL latency_after_idle: cycles=%0d required 256", cyc);
    end
  endtask

  task automatic test_full_3333();
    int cyc;
    set_ops(3, 3, 3, 3);
    do_reset();
    run_to_ov(cyc);
    total++;
    if (cyc != 256) begin
      bad++;
      $display("FAIL latency_3333: cycles=%0d required 256", cyc);
    end
    total++;
    if (bus.z !== 8'd81) begin
      bad++;
      $display("FAIL z_3333: z=%0d required 81", bus.z);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (bus.z !== 8'd81 || bus.ov !== 1'b1) begin
        bad++;
        $display("FAIL hold_3333 cyc %0d: z=%0d ov=%0b required z=81 ov=1", i, bus.z, bus.ov);
      end
    end
  endtask

  task automatic test_vectors();
    int cyc;
    int vec [4][5] = '{'{2, 3, 1, 3, 18}, '{0, 3, 3, 3, 0}, '{3, 2, 2, 1, 12}, '{1, 1, 1, 1, 1}};
    for (int v = 0; v < 4; v++) begin
      set_ops(vec[v][0], vec[v][1], vec[v][2], vec[v][3]);
      do_reset();
      run_to_ov(cyc);
      total++;
      if (cyc != 256 || bus.z !== 8'(vec[v][4])) begin
        bad++;
        $display("FAIL vector %0d: cycles=%0d z=%0d required cycles=256 z=%0d", v, cyc, bus.z, vec[v][4]);
      end
    end
  endtask

  task automatic test_exhaustive();
    int cyc;
    int errs;
    errs = 0;
    for (int t = 0; t < 256; t++) begin
      set_ops(t & 3, (t >> 2) & 3, (t >> 4) & 3, (t >> 6) & 3);
      do_reset();
      run_to_ov(cyc);
      total++;
      if (cyc != 256 || bus.z !== 8'((t & 3) * ((t >> 2) & 3) * ((t >> 4) & 3) * ((t >> 6) & 3))) begin
        bad++;
        errs++;
        if (errs < 8)
          $display("FAIL exhaustive a=%0d b=%0d c=%0d d=%0d: cycles=%0d z=%0d required cycles=256 z=%0d",
                   t & 3, (t >> 2) & 3, (t >> 4) & 3, (t >> 6) & 3, cyc, bus.z,
                   (t & 3) * ((t >> 2) & 3) * ((t >> 4) & 3) * ((t >> 6) & 3));
      end
    end
  endtask

  task automatic test_pause();
    int cyc;
    int exp_mid;
    set_ops(3, 3, 3, 3);
    do_reset();
    exp_mid = model_z(3, 3, 3, 3, 100);
    bus.en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    bus.en = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (bus.z !== 8'(exp_mid) || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL pause_hold: z=%0d ov=%0b required z=%0d ov=0", bus.z, bus.ov, exp_mid);
    end
    run_to_ov(cyc);
    total++;
    if (cyc + 120 != 276) begin
      bad++;
      $display("FAIL pause_latency: cycles=%0d required 276", cyc + 120);
    end
    total++;
    if (bus.z !== 8'd81) begin
      bad++;
      $display("FAIL pause_z: z=%0d required 81", bus.z);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int exp_mid;
    set_ops(3, 3, 3, 3);
    do_reset();
    exp_mid = model_z(3, 3, 3, 3, 100);
    bus.en = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    total++;
    if (bus.z !== 8'(exp_mid)) begin
      bad++;
      $display("FAIL midrun_z: z=%0d required %0d", bus.z, exp_mid);
    end
    rst = 1'b0;
    tick();
    total++;
    if (bus.z !== 8'd0 || bus.ov !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: z=%0d ov=%0b required z=0 ov=0", bus.z, bus.ov);
    end
    set_ops(2, 3, 1, 3);
    rst = 1'b1;
    run_to_ov(cyc);
    total++;
    if (cyc != 256 || bus.z !== 8'd18) begin
      bad++;
      $display("FAIL restart: cycles=%0d z=%0d required cycles=256 z=18", cyc, bus.z);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    bus.en = 1'b0;
    set_ops(0, 0, 0, 0);
    test_reset();
    test_full_3333();
    test_vectors();
    test_pause();
    test_reset_midrun();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
